// File: rtl/note_scroller.sv
// note_scroller: falling-note matrix, pad-strike judge and score/combo keeper.
//
// Each synchronized rising edge of clk32 (a "step") scrolls the note matrix
// down one row and injects a pseudo-random row at the top. Drum-pad strikes
// are judged against the bottom (hit) row.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   clk32        step clock from the 32 pps generator (asynchronous)
//   stop         1 = paused: steps and strikes ignored, outputs hold
//   nivel2       level 2 density (emit every other step)
//   nivel3       level 3 density (emit every step), priority over nivel2
//   pad          raw drum-pad levels, active-high, one bit per lane
//   notes        note matrix, row r at [r*LANES +: LANES], row 0 on top
//   hit_pulse    one-cycle pulse on at least one correct strike
//   miss_pulse   one-cycle pulse on a wrong strike or an escaped note
//   score        saturating score counter
//   combo        saturating consecutive-hit counter
//
// Build option: define COMBO_BONUS_EN to score 2 per hit lane once the
// combo (before increment) has reached 8.
module note_scroller #(
    parameter int unsigned LANES   = 4,
    parameter int unsigned ROWS    = 8,
    parameter int unsigned SCORE_W = 10,
    parameter int unsigned COMBO_W = 6,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clk32,
    input  logic                    stop,
    input  logic                    nivel2,
    input  logic                    nivel3,
    input  logic [LANES-1:0]        pad,
    output logic [ROWS*LANES-1:0]   notes,
    output logic                    hit_pulse,
    output logic                    miss_pulse,
    output logic [SCORE_W-1:0]      score,
    output logic [COMBO_W-1:0]      combo
);

    localparam int unsigned NW = ROWS * LANES;
    localparam int unsigned HB = (ROWS - 1) * LANES;
    localparam int unsigned PW = SCORE_W + 2;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [COMBO_W-1:0] COMBO_MAX = '1;

    // Synchronizers and edge-detect history
    logic             clk32_s1_q, clk32_s2_q, clk32_prev_q;
    logic             clk32_s1_d, clk32_s2_d, clk32_prev_d;
    logic [LANES-1:0] pad_s1_q, pad_s2_q, pad_prev_q;
    logic [LANES-1:0] pad_s1_d, pad_s2_d, pad_prev_d;

    // Game state
    logic [NW-1:0]      notes_q, notes_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [COMBO_W-1:0] combo_q, combo_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [1:0]         step_cnt_q, step_cnt_d;

    // Combinational helpers
    logic             step_c;
    logic [LANES-1:0] strike_c;
    logic [LANES-1:0] hit_row_c, h_c, w_c, left_c;
    logic [PW-1:0]    pts_c, sum_c;
    logic [15:0]      lfsr_next_c;
    logic             emit_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk32_s1_q   <= 1'b0;
            clk32_s2_q   <= 1'b0;
            clk32_prev_q <= 1'b0;
            pad_s1_q     <= '0;
            pad_s2_q     <= '0;
            pad_prev_q   <= '0;
            notes_q      <= '0;
            score_q      <= '0;
            combo_q      <= '0;
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
            lfsr_q       <= SEED;
            step_cnt_q   <= 2'd0;
        end else begin
            clk32_s1_q   <= clk32_s1_d;
            clk32_s2_q   <= clk32_s2_d;
            clk32_prev_q <= clk32_prev_d;
            pad_s1_q     <= pad_s1_d;
            pad_s2_q     <= pad_s2_d;
            pad_prev_q   <= pad_prev_d;
            notes_q      <= notes_d;
            score_q      <= score_d;
            combo_q      <= combo_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            lfsr_q       <= lfsr_d;
            step_cnt_q   <= step_cnt_d;
        end
    end

    // Input conditioning: 2-flop synchronizers keep running even while paused
    always_comb begin
        clk32_s1_d   = clk32;
        clk32_s2_d   = clk32_s1_q;
        clk32_prev_d = clk32_s2_q;
        pad_s1_d     = pad;
        pad_s2_d     = pad_s1_q;
        pad_prev_d   = pad_s2_q;
        step_c       = clk32_s2_q & ~clk32_prev_q;
        strike_c     = pad_s2_q & ~pad_prev_q;
    end

    // Strike judging, scroll, LFSR and counters
    always_comb begin
        notes_d    = notes_q;
        score_d    = score_q;
        combo_d    = combo_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        lfsr_d     = lfsr_q;
        step_cnt_d = step_cnt_q;

        hit_row_c = notes_q[NW-1 -: LANES];
        h_c       = strike_c & hit_row_c;
        w_c       = strike_c & ~hit_row_c;
        left_c    = hit_row_c & ~h_c;

        pts_c = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            pts_c = pts_c + PW'(h_c[l]);
        end
`ifdef COMBO_BONUS_EN
        if (combo_q >= COMBO_W'(8)) begin
            pts_c = pts_c << 1;
        end
`endif
        sum_c = PW'(score_q) + pts_c;

        lfsr_next_c = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
        // step_cnt==0 implies step_cnt[0]==0, so the level rules reduce to an OR
        emit_c = nivel3 | (nivel2 & ~step_cnt_q[0]) | (step_cnt_q == 2'd0);

        if (!stop) begin
            if (h_c != '0) begin
                hit_d   = 1'b1;
                score_d = (sum_c > PW'(SCORE_MAX)) ? SCORE_MAX : SCORE_W'(sum_c);
                combo_d = (combo_q == COMBO_MAX) ? COMBO_MAX : combo_q + COMBO_W'(1);
            end
            if (w_c != '0) begin
                miss_d  = 1'b1;
                combo_d = '0;
            end
            notes_d[NW-1 -: LANES] = left_c;

            // Hits are cleared before the escape check, so a same-cycle hit is not a miss
            if (step_c) begin
                if (left_c != '0) begin
                    miss_d  = 1'b1;
                    combo_d = '0;
                end
                lfsr_d     = lfsr_next_c;
                step_cnt_d = step_cnt_q + 2'd1;
                notes_d    = {notes_q[HB-1:0], emit_c ? lfsr_next_c[LANES-1:0] : LANES'(0)};
            end
        end
    end

    assign notes      = notes_q;
    assign score      = score_q;
    assign combo      = combo_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;

endmodule

// File: tb/tb_note_scroller.sv
// Self-checking bench for note_scroller: constant vector table from reset,
// pause sequence, randomized play against a transaction-level model,
// saturation run and asynchronous reset.
module tb_note_scroller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk32;
    logic        stop;
    logic        nivel2;
    logic        nivel3;
    logic [3:0]  pad;
    logic [31:0] notes;
    logic        hit_pulse;
    logic        miss_pulse;
    logic [9:0]  score;
    logic [5:0]  combo;

    note_scroller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk32      (clk32),
        .stop       (stop),
        .nivel2     (nivel2),
        .nivel3     (nivel3),
        .pad        (pad),
        .notes      (notes),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .score      (score),
        .combo      (combo)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: one 4-bit word per row, plain integer counters
    logic [3:0]  m_notes [8];
    int          m_score;
    int          m_combo;
    int          m_cnt;
    logic [15:0] m_lfsr;
    bit          m_hit;
    bit          m_miss;

    typedef struct {
        bit          st;
        logic [3:0]  pk;
        logic [31:0] notes;
        bit          hit;
        bit          miss;
        int          score;
        int          combo;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_pack();
        logic [31:0] v;
        v = '0;
        for (int r = 0; r < 8; r++) v[r*4 +: 4] = m_notes[r];
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 8; r++) m_notes[r] = 4'h0;
        m_score = 0;
        m_combo = 0;
        m_cnt   = 0;
        m_lfsr  = 16'hACE1;
        m_hit   = 0;
        m_miss  = 0;
    endtask

    // Game rules applied to one transaction (optional step, optional strikes)
    task automatic model_apply(input bit st, input logic [3:0] pk, input bit stp,
                               input bit n2, input bit n3);
        logic [3:0] h, w;
        int pts;
        bit emit;
        m_hit  = 0;
        m_miss = 0;
        if (stp) return;
        h = pk & m_notes[7];
        w = pk & ~m_notes[7];
        if (h != 0) begin
            pts = $countones(h);
`ifdef COMBO_BONUS_EN
            if (m_combo >= 8) pts = pts * 2;
`endif
            m_score = (m_score + pts > 1023) ? 1023 : m_score + pts;
            m_combo = (m_combo + 1 > 63) ? 63 : m_combo + 1;
            m_hit = 1;
            m_notes[7] = m_notes[7] & ~h;
        end
        if (w != 0) begin
            m_miss  = 1;
            m_combo = 0;
        end
        if (st) begin
            if (m_notes[7] != 0) begin
                m_miss  = 1;
                m_combo = 0;
            end
            for (int r = 7; r > 0; r--) m_notes[r] = m_notes[r-1];
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
            if (n3)      emit = 1;
            else if (n2) emit = (m_cnt % 2) == 0;
            else         emit = (m_cnt == 0);
            m_notes[0] = emit ? m_lfsr[3:0] : 4'h0;
            m_cnt = (m_cnt + 1) % 4;
        end
    endtask

    // Drive one transaction, wait out the synchronizer latency, check, then idle
    task automatic do_event(input bit st, input logic [3:0] pk, input bit stp,
                            input bit n2, input bit n3);
        @(negedge clk);
        stop = stp; nivel2 = n2; nivel3 = n3;
        clk32 = st; pad = pk;
        model_apply(st, pk, stp, n2, n3);
        repeat (3) @(posedge clk);
        #1;
        chk("notes", notes, m_pack());
        chk("score", 32'(score), 32'(m_score));
        chk("combo", 32'(combo), 32'(m_combo));
        chk("hit_pulse", 32'(hit_pulse), 32'(m_hit));
        chk("miss_pulse", 32'(miss_pulse), 32'(m_miss));
        @(negedge clk);
        clk32 = 1'b0; pad = 4'h0;
        @(posedge clk);
        #1;
        chk("hit_pulse_width", 32'(hit_pulse), 32'd0);
        chk("miss_pulse_width", 32'(miss_pulse), 32'd0);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int guard;
        logic [3:0] pk;
        bit st, stp, n2, n3;
        logic [31:0] frozen;

        // nivel3, no strikes: rows come from the advanced SEED (E270, 7138, ...)
        tbl[0]  = '{1, 4'h0, 32'h00000000, 0, 0, 0, 0};
        tbl[1]  = '{1, 4'h0, 32'h00000008, 0, 0, 0, 0};
        tbl[2]  = '{1, 4'h0, 32'h0000008C, 0, 0, 0, 0};
        tbl[3]  = '{1, 4'h0, 32'h000008CE, 0, 0, 0, 0};
        tbl[4]  = '{1, 4'h0, 32'h00008CE7, 0, 0, 0, 0};
        tbl[5]  = '{1, 4'h0, 32'h0008CE73, 0, 0, 0, 0};
        tbl[6]  = '{1, 4'h0, 32'h008CE739, 0, 0, 0, 0};
        tbl[7]  = '{1, 4'h0, 32'h08CE7394, 0, 0, 0, 0};
        tbl[8]  = '{1, 4'h0, 32'h8CE73942, 0, 0, 0, 0};
        // Strike on the row-7 note in the same cycle as a step: hit, no escape
        tbl[9]  = '{1, 4'h8, 32'hCE739421, 1, 0, 1, 1};
        // Unstruck row 7 escapes
        tbl[10] = '{1, 4'h0, 32'hE7394218, 0, 1, 1, 0};
        // Wrong lane, no step
        tbl[11] = '{0, 4'h1, 32'hE7394218, 0, 1, 1, 0};
        // Two-lane hit without step
        tbl[12] = '{0, 4'h6, 32'h87394218, 1, 0, 3, 1};

        rst_n = 1'b0; clk32 = 1'b0; stop = 1'b0; nivel2 = 1'b0; nivel3 = 1'b0; pad = 4'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_notes", notes, 32'h0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_combo", 32'(combo), 32'd0);
        chk("rst_hit", 32'(hit_pulse), 32'd0);
        chk("rst_miss", 32'(miss_pulse), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 13; i++) begin
            do_event(tbl[i].st, tbl[i].pk, 0, 0, 1);
            chk($sformatf("tbl%0d_notes", i), notes, tbl[i].notes);
            chk($sformatf("tbl%0d_score", i), 32'(score), 32'(tbl[i].score));
            chk($sformatf("tbl%0d_combo", i), 32'(combo), 32'(tbl[i].combo));
        end
        // Pulses of the last table entry, as captured by the model comparison
        chk("tbl12_model_hit", 32'(m_hit), 32'(tbl[12].hit));

        // Pause: ten steps with strikes, everything frozen
        frozen = notes;
        for (int i = 0; i < 10; i++) begin
            do_event(1, 4'($urandom_range(1, 15)), 1, 0, 1);
        end
        chk("pause_notes", notes, frozen);
        chk("pause_score", 32'(score), 32'd3);

        // Randomized play
        for (int i = 0; i < 250; i++) begin
            st  = ($urandom % 4) != 0;
            case ($urandom % 4)
                0, 1:    pk = m_notes[7];
                2:       pk = 4'($urandom);
                default: pk = 4'h0;
            endcase
            stp = ($urandom % 8) == 0;
            n2  = 1'($urandom);
            n3  = 1'($urandom);
            do_event(st, pk, stp, n2, n3);
        end

        // Hit every note until the score saturates, then keep hitting
        guard = 0;
        while (m_score < 1023 && guard < 3000) begin
            do_event(1, m_notes[7], 0, 0, 1);
            guard++;
        end
        chk("sat_reached", 32'(guard < 3000), 32'd1);
        for (int i = 0; i < 6; i++) do_event(1, m_notes[7], 0, 0, 1);
        chk("score_sat", 32'(score), 32'd1023);
        chk("combo_sat", 32'(combo), 32'd63);

        // Asynchronous reset between clock edges
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_notes", notes, 32'h0);
        chk("arst_score", 32'(score), 32'd0);
        chk("arst_combo", 32'(combo), 32'd0);
        chk("arst_hit", 32'(hit_pulse), 32'd0);
        chk("arst_miss", 32'(miss_pulse), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/note_scroller.md
Name: note_scroller

Overview:
- Game-play stage directly downstream of the 32 pps step clock generator (clk32 output, gated by stop/nivel2/nivel3).
- Consumes clk32 as a step tick: on every step, scrolls the falling-note matrix down one row and injects a new pseudo-random row at the top.
- Judges drum-pad strikes against the bottom row and keeps score/combo counters.
- Feeds the VGA renderer (notes) and the score display.

Parameters:
- LANES, 4, number of drum lanes (pads).
- ROWS, 8, rows in the visible note matrix; row ROWS-1 is the hit row.
- SCORE_W, 10, score counter width.
- COMBO_W, 6, combo counter width.
- SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- clk32  input  1  step clock from the 32 pps generator; asynchronous to clk's phase.
- stop  input  1  1 = game paused.
- nivel2  input  1  level 2 density select.
- nivel3  input  1  level 3 density select; has priority over nivel2.
- pad  input  LANES  raw drum-pad levels, active-high.
- notes  output  ROWS*LANES  note matrix; bits [r*LANES +: LANES] = row r; row 0 is the top row.
- hit_pulse  output  1  one-clk pulse on at least one correct strike.
- miss_pulse  output  1  one-clk pulse on a wrong strike or an escaped note.
- score  output  SCORE_W  accumulated score.
- combo  output  COMBO_W  consecutive-hit counter.

Behaviour:
- Reset (async assert, synchronous release):
  - notes=0, score=0, combo=0, hit_pulse=0, miss_pulse=0.
  - LFSR=SEED, step_cnt=0, all synchronizer flops=0.
- Input conditioning:
  - clk32 and each pad bit pass through a 2-flop synchronizer plus a rising-edge detect.
  - step = 1-cycle pulse; strike[L] = 1-cycle pulse per lane.
  - Latency: a rising input edge updates notes/score/pulses on the 3rd clk edge after it is first sampled.
- Pause: while stop=1, step and strike are ignored and all outputs hold their values (pulses stay 0). Synchronizers keep running.
- Step processing, stop=0:
  - Escape check: any 1 left in the pre-shift row ROWS-1 (after same-cycle hit clearing) → miss_pulse=1, combo=0.
  - Shift: row r ← row r-1 for r=1..ROWS-1.
  - LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11; advances once per step.
  - step_cnt: 2-bit, increments per step, wraps.
  - Emit rule: nivel3 → every step; else nivel2 → when step_cnt[0]=0; else when step_cnt=0.
  - Row 0 ← LFSR[LANES-1:0] (post-advance value) if emit, else 0.
- Strike judging, stop=0, evaluated against the pre-shift row ROWS-1:
  - h = strike & row; w = strike & ~row.
  - If h≠0: clear the h bits, hit_pulse=1, score += popcount(h), combo += 1 (once per cycle).
  - If w≠0: miss_pulse=1, combo=0.
  - If both h≠0 and w≠0: hit_pulse=1, miss_pulse=1; score is still added and combo ends at 0.
- Simultaneous step and strike: the strike is judged first. A note hit in the same cycle it would escape counts as a hit, not a miss.
- Saturation: score clamps at 2^SCORE_W-1; combo clamps at 2^COMBO_W-1. Neither wraps.
- Level changes take effect on the next step; stop toggling does not reset step_cnt.

Optional Feature:
- COMBO_BONUS_EN defined: each hit lane scores 2 instead of 1 when combo (pre-increment) ≥ 8.
- COMBO_BONUS_EN undefined: each hit lane always scores 1.
- Port list is identical in both builds.

Test Plan:
- Reset release, nivel3=1, stop=0, four clk32 edges → notes row0 = LFSR[3:0] after each advance, rows shift; first emitted row = low nibble of the advanced SEED; score=0.
- Note 4'b0010 reaches row 7; pad[1] pulse → hit_pulse 1 cycle, score 0→1, combo 0→1, bit cleared; next step gives no miss.
- Note 4'b0001 in row 7, no strike, clk32 edge → miss_pulse=1, combo reset 5→0, score unchanged.
- pad[1] strike lands in the same clk cycle as step, row 7 = 4'b0010 → hit_pulse=1, miss_pulse=0, score +1.
- stop=1: 10 clk32 edges plus pad strikes → notes, score, combo frozen; pulses stay 0.
- Force score to 1023 and hit 2 lanes → score stays 1023. With COMBO_BONUS_EN and combo=8, a single-lane hit → score +2, combo 9.
- rst_n pulled low mid-step (async, between clk edges) → all outputs 0 immediately.
